// File: rtl/nor_bus_pkg.sv
// Shared types and helpers for the NOR flash bus scheduler.
package nor_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PULSE   = 3'd2,
    HOLD    = 3'd3,
    WAIT_RY = 3'd4
  } state_e;

  localparam int N_PORTS = 2;
  localparam int TO_W    = 16;

  // The phase counter holds (length - 1), so it needs clog2 of the longest phase.
  function automatic int cnt_w(input int t_setup, input int t_pulse, input int t_hold);
    int m;
    m = t_setup;
    if (t_pulse > m) m = t_pulse;
    else m = m;
    if (t_hold > m) m = t_hold;
    else m = m;
    if (m > 1) return $clog2(m);
    else return 1;
  endfunction

endpackage

// File: rtl/nor_ry_sync.sv
// Two-flop synchronizer for the asynchronous NOR RY/BY line; resets to ready.
module nor_ry_sync (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic ry_i,
  output logic ry_s_o
);

  logic r_meta;
  logic r_sync;

  // Synchronizer chain
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= ry_i;
      r_sync <= r_meta;
    end
  end

  assign ry_s_o = r_sync;

endmodule

// File: rtl/nor_bus_sched.sv
// Two-port round-robin arbiter and setup/strobe/hold sequencer for a shared NOR bus.
// Optional RY/BY busy-wait timeout: define NOR_BUS_SCHED_RY_TIMEOUT_EN.
module nor_bus_sched
  import nor_bus_pkg::*;
#(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 16,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 6,
  parameter int T_HOLD  = 2,
  parameter int TO_CYC  = 65535
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [N_PORTS-1:0] req_i,
  input  logic [N_PORTS-1:0] we_i,
  input  logic [ADDR_W-1:0]  addr0_i,
  input  logic [ADDR_W-1:0]  addr1_i,
  input  logic [DATA_W-1:0]  wdata0_i,
  input  logic [DATA_W-1:0]  wdata1_i,
  output logic [N_PORTS-1:0] ack_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               err_o,
  output logic               busy_o,
  output logic [ADDR_W-1:0]  nor_addr_o,
  output logic [DATA_W-1:0]  nor_data_o,
  output logic               nor_data_oe,
  input  logic [DATA_W-1:0]  nor_data_i,
  output logic               nor_ce_o,
  output logic               nor_oe_o,
  output logic               nor_we_o,
  input  logic               nor_ry_i
);

  localparam int               CNT_W    = cnt_w(T_SETUP, T_PULSE, T_HOLD);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_port, w_port_nxt;
  logic                r_wr, w_wr_nxt;
  logic                r_last, w_last_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_ce, w_ce_nxt;
  logic                r_oe, w_oe_nxt;
  logic                r_we, w_we_nxt;
  logic                r_doe, w_doe_nxt;
  logic [N_PORTS-1:0]  r_ack, w_ack_nxt;
  logic                r_err, w_err_nxt;
  logic                r_busy, w_busy_nxt;
  logic [N_PORTS-1:0]  w_req;
  logic                w_gnt;
  logic                w_ry_s;
  logic                w_to_hit;

  nor_ry_sync u_ry_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .ry_i      (nor_ry_i),
    .ry_s_o    (w_ry_s)
  );

  // The port being acked still shows its old request this cycle, so mask it.
  assign w_req = req_i & ~r_ack;

  // Next-state, next-output and grant logic; strobes are registered from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_port_nxt  = r_port;
    w_wr_nxt    = r_wr;
    w_last_nxt  = r_last;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_rdata_nxt = r_rdata;
    w_ce_nxt    = 1'b1;
    w_oe_nxt    = 1'b1;
    w_we_nxt    = 1'b1;
    w_doe_nxt   = 1'b0;
    w_ack_nxt   = 2'b00;
    w_err_nxt   = 1'b0;
    w_gnt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req != 2'b00) begin
          if (w_req == 2'b11) begin
            w_gnt      = ~r_last;
            w_last_nxt = ~r_last;
          end else begin
            w_gnt = w_req[1];
          end
          w_port_nxt  = w_gnt;
          w_wr_nxt    = we_i[w_gnt];
          w_addr_nxt  = w_gnt ? addr1_i : addr0_i;
          w_data_nxt  = w_gnt ? wdata1_i : wdata0_i;
          w_state_nxt = SETUP;
          w_cnt_nxt   = LD_SETUP;
          w_ce_nxt    = 1'b0;
          w_doe_nxt   = we_i[w_gnt];
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETUP: begin
        w_ce_nxt  = 1'b0;
        w_doe_nxt = r_wr;
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = LD_PULSE;
          w_oe_nxt    = r_wr;
          w_we_nxt    = ~r_wr;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      PULSE: begin
        w_ce_nxt  = 1'b0;
        w_doe_nxt = r_wr;
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = LD_HOLD;
          if (!r_wr) w_rdata_nxt = nor_data_i;
          else       w_rdata_nxt = r_rdata;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          w_oe_nxt  = r_wr;
          w_we_nxt  = ~r_wr;
        end
      end
      HOLD: begin
        if (r_cnt == CNT_ZERO) begin
          if (w_ry_s) begin
            w_state_nxt = IDLE;
            w_ack_nxt   = r_port ? 2'b10 : 2'b01;
          end else begin
            w_state_nxt = WAIT_RY;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          w_ce_nxt  = 1'b0;
          w_doe_nxt = r_wr;
        end
      end
      WAIT_RY: begin
        if (w_ry_s) begin
          w_state_nxt = IDLE;
          w_ack_nxt   = r_port ? 2'b10 : 2'b01;
        end else if (w_to_hit) begin
          w_state_nxt = IDLE;
          w_ack_nxt   = r_port ? 2'b10 : 2'b01;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = WAIT_RY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and registered bus/requester outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
      r_port  <= 1'b0;
      r_wr    <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= {ADDR_W{1'b0}};
      r_data  <= {DATA_W{1'b0}};
      r_rdata <= {DATA_W{1'b0}};
      r_ce    <= 1'b1;
      r_oe    <= 1'b1;
      r_we    <= 1'b1;
      r_doe   <= 1'b0;
      r_ack   <= 2'b00;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_port  <= w_port_nxt;
      r_wr    <= w_wr_nxt;
      r_last  <= w_last_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_rdata <= w_rdata_nxt;
      r_ce    <= w_ce_nxt;
      r_oe    <= w_oe_nxt;
      r_we    <= w_we_nxt;
      r_doe   <= w_doe_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

`ifdef NOR_BUS_SCHED_RY_TIMEOUT_EN
  logic [TO_W-1:0] r_to;

  // Counts consecutive WAIT_RY cycles; cleared in every other state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_to <= {TO_W{1'b0}};
    end else if (r_state == WAIT_RY) begin
      r_to <= r_to + TO_W'(1'b1);
    end else begin
      r_to <= {TO_W{1'b0}};
    end
  end

  assign w_to_hit = (r_to == TO_W'(TO_CYC - 1));
`else
  logic [TO_W-1:0] w_unused_to;
  assign w_unused_to = TO_W'(TO_CYC);
  assign w_to_hit    = 1'b0;
`endif

  assign ack_o       = r_ack;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign busy_o      = r_busy;
  assign nor_addr_o  = r_addr;
  assign nor_data_o  = r_data;
  assign nor_data_oe = r_doe;
  assign nor_ce_o    = r_ce;
  assign nor_oe_o    = r_oe;
  assign nor_we_o    = r_we;

endmodule

// File: tb/tb_nor_bus_sched.sv
// Self-checking bench for nor_bus_sched: directed scenarios plus random single transactions.
module tb_nor_bus_sched;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;
  localparam int TS = 2;
  localparam int TP = 6;
  localparam int TH = 2;
`ifdef NOR_BUS_SCHED_RY_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 65535;
`endif
  localparam int LAT    = 1 + TS + TP + TH;
  localparam int CE_LOW = TS + TP + TH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_i, we_i, ack_o;
  logic [ADDR_W-1:0] addr0_i, addr1_i, nor_addr_o;
  logic [DATA_W-1:0] wdata0_i, wdata1_i, rdata_o, nor_data_o, nor_data_i;
  logic              err_o, busy_o, nor_data_oe, nor_ce_o, nor_oe_o, nor_we_o, nor_ry_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nor_bus_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .TO_CYC(TO_CYC)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .nor_addr_o(nor_addr_o), .nor_data_o(nor_data_o), .nor_data_oe(nor_data_oe),
    .nor_data_i(nor_data_i), .nor_ce_o(nor_ce_o), .nor_oe_o(nor_oe_o), .nor_we_o(nor_we_o),
    .nor_ry_i(nor_ry_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on one port with ry held high; the bench models the
  // bus as per-strobe cycle counts, the registered address/data and the ack latency.
  task automatic run_txn(input int port, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rv);
    int lat = 0, n_ce = 0, n_oe = 0, n_we = 0, n_doe = 0, bad_a = 0, bad_d = 0;
    logic got = 1'b0;
    logic [1:0] ack = 2'b00;
    logic [DATA_W-1:0] rd = '0;
    logic er = 1'b0;
    req_i = 2'b00;
    we_i  = 2'($urandom);
    addr0_i = ADDR_W'($urandom); addr1_i = ADDR_W'($urandom);
    wdata0_i = DATA_W'($urandom); wdata1_i = DATA_W'($urandom);
    if (port == 0) begin addr0_i = a; wdata0_i = d; we_i[0] = wr; req_i = 2'b01; end
    else           begin addr1_i = a; wdata1_i = d; we_i[1] = wr; req_i = 2'b10; end
    nor_data_i = ~rv;
    for (int i = 0; i < 4 * LAT && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        addr0_i = ADDR_W'($urandom); addr1_i = ADDR_W'($urandom);
        wdata0_i = DATA_W'($urandom); wdata1_i = DATA_W'($urandom);
        we_i = 2'($urandom);
      end
      if (!nor_ce_o) begin n_ce++; if (nor_addr_o !== a) bad_a++; end
      if (!nor_oe_o) n_oe++;
      if (!nor_we_o) n_we++;
      if (nor_data_oe) begin n_doe++; if (nor_data_o !== d) bad_d++; end
      nor_data_i = (!nor_oe_o) ? rv : ~rv;
      if (ack_o != 2'b00) begin got = 1'b1; ack = ack_o; rd = rdata_o; er = err_o; end
    end
    req_i = 2'b00;
    chk("txn_latency", lat, LAT);
    chk("txn_ack", 32'(ack), (port == 0) ? 32'd1 : 32'd2);
    chk("txn_ce_low", n_ce, CE_LOW);
    chk("txn_oe_low", n_oe, wr ? 0 : TP);
    chk("txn_we_low", n_we, wr ? TP : 0);
    chk("txn_dq_oe", n_doe, wr ? CE_LOW : 0);
    chk("txn_addr", bad_a, 0);
    chk("txn_wdata", bad_d, 0);
    chk("txn_err", 32'(er), 32'd0);
    if (!wr) chk("txn_rdata", 32'(rd), 32'(rv));
  endtask

  initial begin
    int n_ack, n_odd, lat, k;
    logic got;
    logic [1:0] ack;
    logic [1:0] seq [4];
    int when [4];

    rst_n = 1'b0; req_i = 2'b00; we_i = 2'b00;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    nor_data_i = '0; nor_ry_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ce", 32'(nor_ce_o), 32'd1);
    chk("rst_oe", 32'(nor_oe_o), 32'd1);
    chk("rst_we", 32'(nor_we_o), 32'd1);
    chk("rst_dq_oe", 32'(nor_data_oe), 32'd0);
    chk("rst_addr", 32'(nor_addr_o), 32'd0);
    chk("rst_data", 32'(nor_data_o), 32'd0);
    chk("rst_rdata", 32'(rdata_o), 32'd0);
    chk("rst_ack_err_busy", {29'd0, ack_o, err_o | busy_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, 1'b0, 26'h0123456, 16'h0000, 16'hBEEF);
    @(negedge clk);
    run_txn(1, 1'b1, 26'h3FFFFFF, 16'hA55A, 16'h0000);
    @(negedge clk);
    chk("addr_held_idle", 32'(nor_addr_o), 32'h3FFFFFF);

    // Contention straight out of reset: both requests held continuously.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    addr0_i = 26'h0000AAA; addr1_i = 26'h0000BBB; we_i = 2'b00;
    for (int i = 0; i < 4; i++) begin seq[i] = 2'b00; when[i] = 0; end
    k = 0;
    req_i = 2'b11;
    for (int t = 1; t <= 6 * LAT && k < 4; t++) begin
      @(negedge clk);
      if (ack_o != 2'b00) begin seq[k] = ack_o; when[k] = t; k++; end
    end
    req_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("arb_order", 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("arb_time", when[i], (i + 1) * LAT);
    end

    // Write where the device reports busy: ry low early enough to be seen at end of HOLD.
    @(negedge clk);
    req_i = 2'b01; we_i = 2'b01; addr0_i = 26'h0155AA0; wdata0_i = 16'h5AA5;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i == 3) nor_ry_i = 1'b0;
    end
    chk("wait_no_ack", 32'(ack_o), 32'd0);
    chk("wait_ce_high", 32'(nor_ce_o), 32'd1);
    chk("wait_dq_released", 32'(nor_data_oe), 32'd0);
    chk("wait_busy", 32'(busy_o), 32'd1);
    n_odd = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack_o != 2'b00 || !nor_ce_o || nor_data_oe || !busy_o) n_odd++;
    end
    chk("wait_steady", n_odd, 0);
    nor_ry_i = 1'b1;
    lat = 0; got = 1'b0; ack = 2'b00;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (ack_o != 2'b00) begin got = 1'b1; lat = i; ack = ack_o; end
    end
    req_i = 2'b00;
    chk("wait_ack_delay", lat, 3);
    chk("wait_ack", 32'(ack), 32'd1);

    // Asynchronous reset in the middle of a write strobe.
    @(negedge clk);
    req_i = 2'b10; we_i = 2'b10; addr1_i = 26'h2AAAAAA; wdata1_i = 16'h1234;
    repeat (5) @(negedge clk);
    chk("abort_we_low", 32'(nor_we_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes", {29'd0, nor_ce_o, nor_oe_o, nor_we_o}, 32'd7);
    chk("abort_dq_oe", 32'(nor_data_oe), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    req_i = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack_o != 2'b00) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);
    run_txn(1, 1'b1, 26'h2AAAAAA, 16'h1234, 16'h0000);

    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), ADDR_W'($urandom),
              DATA_W'($urandom), DATA_W'($urandom));
    end

`ifdef NOR_BUS_SCHED_RY_TIMEOUT_EN
    @(negedge clk);
    req_i = 2'b01; we_i = 2'b01; addr0_i = 26'h0000321; wdata0_i = 16'h0F0F;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i == 3) nor_ry_i = 1'b0;
    end
    chk("to_entered_wait", {30'd0, busy_o, nor_ce_o}, 32'd3);
    lat = 0; got = 1'b0; ack = 2'b00;
    for (int i = 1; i <= TO_CYC + 20 && !got; i++) begin
      @(negedge clk);
      if (ack_o != 2'b00) begin got = 1'b1; lat = i; ack = ack_o; chk("to_err", 32'(err_o), 32'd1); end
    end
    req_i = 2'b00;
    chk("to_delay", lat, TO_CYC);
    chk("to_ack", 32'(ack), 32'd1);
    nor_ry_i = 1'b1;
    repeat (3) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
